// File: rtl/coord_stack_pkg.sv
// Shared types and constants for the coordinate stack arbiter.
package coord_stack_pkg;

    localparam int COORD_W   = 4;
    localparam int DEPTH_DEF = 64;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Onehot grant vector for a single requester id.
    function automatic logic [1:0] id_to_onehot(input logic id);
        logic [1:0] oh;
        if (id == 1'b1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, on contention
// the prio input picks the winner (0 = requester 0, 1 = requester 1).
module rr_arbiter2
    import coord_stack_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Pick a onehot winner from the request vector and current priority.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = id_to_onehot(prio);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/coord_stack_arbiter.sv
// Shares one push/pop coordinate stack between two requesters. Grants
// round-robin, sequences the stack strobes, captures pop data and guards
// against overflow/underflow using its own occupancy counter.
module coord_stack_arbiter
    import coord_stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_op,
    input  logic [3:0]       r0_x_in,
    input  logic [3:0]       r0_y_in,
    output logic             r0_done,
    output logic             r0_err,
    output logic [3:0]       r0_x_out,
    output logic [3:0]       r0_y_out,
    input  logic             r1_req,
    input  logic             r1_op,
    input  logic [3:0]       r1_x_in,
    input  logic [3:0]       r1_y_in,
    output logic             r1_done,
    output logic             r1_err,
    output logic [3:0]       r1_x_out,
    output logic [3:0]       r1_y_out,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [3:0]       stk_x_in,
    output logic [3:0]       stk_y_in,
    input  logic [3:0]       stk_x_out,
    input  logic [3:0]       stk_y_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    state_t             state_r;
    state_t             state_s;
    logic               prio_r;
    logic               id_r;
    logic               op_r;
    logic [CNT_W-1:0]   count_r;

    logic [1:0]         req_s;
    logic [1:0]         gnt_s;
    logic               grant_s;
    logic               win_id_s;
    logic               win_op_s;
    logic [COORD_W-1:0] win_x_s;
    logic [COORD_W-1:0] win_y_s;
    logic               full_s;
    logic               empty_s;
    logic               reject_s;
    logic               issue_push_s;
    logic               issue_pop_s;
    logic               resp_s;
    logic               resp_id_s;
    logic               resp_err_s;

    logic               r0_done_r;
    logic               r0_err_r;
    logic [COORD_W-1:0] r0_x_out_r;
    logic [COORD_W-1:0] r0_y_out_r;
    logic               r1_done_r;
    logic               r1_err_r;
    logic [COORD_W-1:0] r1_x_out_r;
    logic [COORD_W-1:0] r1_y_out_r;
    logic               stk_push_r;
    logic               stk_pop_r;
    logic [COORD_W-1:0] stk_x_in_r;
    logic [COORD_W-1:0] stk_y_in_r;

    assign req_s = {r1_req, r0_req};

    rr_arbiter2 u_rr (
        .req  (req_s),
        .prio (prio_r),
        .gnt  (gnt_s)
    );

    // Winner selection, legality check and next-state decode.
    always_comb begin
        grant_s  = |gnt_s;
        win_id_s = gnt_s[1];
        if (win_id_s) begin
            win_op_s = r1_op;
            win_x_s  = r1_x_in;
            win_y_s  = r1_y_in;
        end else begin
            win_op_s = r0_op;
            win_x_s  = r0_x_in;
            win_y_s  = r0_y_in;
        end

        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == ZERO_C);
        if (win_op_s == OP_PUSH) begin
            reject_s = full_s;
        end else begin
            reject_s = empty_s;
        end

        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s && reject_s) begin
                    state_s = RESP;
                end else if (grant_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (op_r == OP_POP) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = RESP;
                end
            end
            CAPTURE: state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        issue_push_s = (state_r == IDLE) && (state_s == ISSUE) && (win_op_s == OP_PUSH);
        issue_pop_s  = (state_r == IDLE) && (state_s == ISSUE) && (win_op_s == OP_POP);
        resp_s       = (state_s == RESP);
        // Only the direct IDLE->RESP path is a rejection; issued ops always succeed.
        if (state_r == IDLE) begin
            resp_id_s  = win_id_s;
            resp_err_s = reject_s;
        end else begin
            resp_id_s  = id_r;
            resp_err_s = 1'b0;
        end
    end

    // FSM state, latched winner and round-robin priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
            id_r    <= 1'b0;
            op_r    <= OP_PUSH;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && grant_s) begin
                id_r <= win_id_s;
                op_r <= win_op_s;
            end
            if (state_r == RESP) begin
                prio_r <= ~id_r;
            end
        end
    end

    // Occupancy counter, moved on the edge that ends the strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_C;
        end else if (state_r == ISSUE) begin
            if (op_r == OP_PUSH) begin
                count_r <= count_r + ONE_C;
            end else begin
                count_r <= count_r - ONE_C;
            end
        end
    end

    // Stack strobes and write data, registered so they are high exactly in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_push_r <= 1'b0;
            stk_pop_r  <= 1'b0;
            stk_x_in_r <= 4'h0;
            stk_y_in_r <= 4'h0;
        end else begin
            stk_push_r <= issue_push_s;
            stk_pop_r  <= issue_pop_s;
            stk_x_in_r <= issue_push_s ? win_x_s : 4'h0;
            stk_y_in_r <= issue_push_s ? win_y_s : 4'h0;
        end
    end

    // Completion pulse and error flag, registered on entry to RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_done_r <= 1'b0;
            r0_err_r  <= 1'b0;
            r1_done_r <= 1'b0;
            r1_err_r  <= 1'b0;
        end else begin
            r0_done_r <= resp_s && (resp_id_s == 1'b0);
            r0_err_r  <= resp_s && (resp_id_s == 1'b0) && resp_err_s;
            r1_done_r <= resp_s && (resp_id_s == 1'b1);
            r1_err_r  <= resp_s && (resp_id_s == 1'b1) && resp_err_s;
        end
    end

    // Pop data lands in the winner's output registers at the end of CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_x_out_r <= 4'h0;
            r0_y_out_r <= 4'h0;
            r1_x_out_r <= 4'h0;
            r1_y_out_r <= 4'h0;
        end else if (state_r == CAPTURE) begin
            if (id_r == 1'b0) begin
                r0_x_out_r <= stk_x_out;
                r0_y_out_r <= stk_y_out;
            end else begin
                r1_x_out_r <= stk_x_out;
                r1_y_out_r <= stk_y_out;
            end
        end
    end

    assign r0_done  = r0_done_r;
    assign r0_err   = r0_err_r;
    assign r0_x_out = r0_x_out_r;
    assign r0_y_out = r0_y_out_r;
    assign r1_done  = r1_done_r;
    assign r1_err   = r1_err_r;
    assign r1_x_out = r1_x_out_r;
    assign r1_y_out = r1_y_out_r;
    assign stk_push = stk_push_r;
    assign stk_pop  = stk_pop_r;
    assign stk_x_in = stk_x_in_r;
    assign stk_y_in = stk_y_in_r;
    assign count    = count_r;
    assign full     = full_s;
    assign empty    = empty_s;
    assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_coord_stack_arbiter.sv
// Randomized bench for coord_stack_arbiter: a queue-based LIFO model predicts
// winners, errors, latencies, occupancy and pop data for every completion.
module tb_coord_stack_arbiter;
    import coord_stack_pkg::*;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    logic rst;
    logic r0_req, r0_op, r1_req, r1_op;
    logic [3:0] r0_x_in, r0_y_in, r1_x_in, r1_y_in;
    logic r0_done, r0_err, r1_done, r1_err;
    logic [3:0] r0_x_out, r0_y_out, r1_x_out, r1_y_out;
    logic stk_push, stk_pop;
    logic [3:0] stk_x_in, stk_y_in, stk_x_out, stk_y_out;
    logic [CNT_W-1:0] count;
    logic full, empty, busy;

    always #5 clk = ~clk;

    coord_stack_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_op(r0_op), .r0_x_in(r0_x_in), .r0_y_in(r0_y_in),
        .r0_done(r0_done), .r0_err(r0_err), .r0_x_out(r0_x_out), .r0_y_out(r0_y_out),
        .r1_req(r1_req), .r1_op(r1_op), .r1_x_in(r1_x_in), .r1_y_in(r1_y_in),
        .r1_done(r1_done), .r1_err(r1_err), .r1_x_out(r1_x_out), .r1_y_out(r1_y_out),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_x_in(stk_x_in), .stk_y_in(stk_y_in),
        .stk_x_out(stk_x_out), .stk_y_out(stk_y_out),
        .count(count), .full(full), .empty(empty), .busy(busy)
    );

    // Physical stack attached to the DUT: read data valid the cycle after the pop edge.
    logic [7:0] stk_mem [DEPTH];
    int sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= 0;
            stk_x_out <= 4'h0;
            stk_y_out <= 4'h0;
        end else if (stk_push) begin
            if (sp < DEPTH) stk_mem[sp] <= {stk_x_in, stk_y_in};
            sp <= sp + 1;
        end else if (stk_pop) begin
            if (sp > 0) {stk_x_out, stk_y_out} <= stk_mem[sp-1];
            sp <= sp - 1;
        end
    end

    // Strobe counters used to check that each transaction issues the right strobes.
    int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
    end

    typedef struct packed {
        logic       op;
        logic [3:0] x;
        logic [3:0] y;
    } txn_t;

    int n_cmp = 0;
    int n_err = 0;
    txn_t txq0[$];
    txn_t txq1[$];
    logic [7:0] model_q[$];
    logic model_prio;
    logic [3:0] exp_xo[2];
    logic [3:0] exp_yo[2];

    task automatic model_reset();
        model_q.delete();
        model_prio = 1'b0;
        exp_xo[0] = 4'h0; exp_yo[0] = 4'h0;
        exp_xo[1] = 4'h0; exp_yo[1] = 4'h0;
    endtask

    task automatic drive_req(input int id, input logic rq, input txn_t t);
        if (id == 0) begin
            r0_req = rq; r0_op = t.op; r0_x_in = t.x; r0_y_in = t.y;
        end else begin
            r1_req = rq; r1_op = t.op; r1_x_in = t.x; r1_y_in = t.y;
        end
    endtask

    function automatic txn_t rand_txn(input int mode);
        txn_t t;
        t.op = (mode == 1) ? OP_PUSH : (mode == 2) ? OP_POP : 1'($urandom_range(1, 0));
        t.x = 4'($urandom_range(15, 0));
        t.y = 4'($urandom_range(15, 0));
        return t;
    endfunction

    // Runs both request queues to completion, checking each done against the model.
    task automatic run_engine(input string tag);
        bit act[2];
        txn_t cur[2];
        txn_t t;
        int gap, e_gap, e_lat, e_push, e_pop, ps, pp;
        bit first;
        logic exp_id, e_err, obs_err;
        logic [7:0] d;
        act[0] = 1'b0; act[1] = 1'b0;
        first = 1'b1; gap = 0;
        @(negedge clk);
        if (txq0.size() > 0) begin cur[0] = txq0.pop_front(); drive_req(0, 1'b1, cur[0]); act[0] = 1'b1; end
        if (txq1.size() > 0) begin cur[1] = txq1.pop_front(); drive_req(1, 1'b1, cur[1]); act[1] = 1'b1; end
        ps = push_cnt; pp = pop_cnt;
        while (act[0] || act[1]) begin
            @(negedge clk);
            gap++;
            if (r0_done || r1_done) begin
                exp_id = (act[0] && act[1]) ? model_prio : logic'(act[1]);
                t = cur[exp_id];
                e_push = 0; e_pop = 0;
                if (t.op == OP_PUSH) begin
                    if (model_q.size() == DEPTH) begin e_err = 1'b1; e_lat = 1; end
                    else begin model_q.push_back({t.x, t.y}); e_err = 1'b0; e_lat = 2; e_push = 1; end
                end else begin
                    if (model_q.size() == 0) begin e_err = 1'b1; e_lat = 1; end
                    else begin
                        d = model_q.pop_back();
                        exp_xo[exp_id] = d[7:4]; exp_yo[exp_id] = d[3:0];
                        e_err = 1'b0; e_lat = 3; e_pop = 1;
                    end
                end
                e_gap = first ? e_lat : e_lat + 1;
                obs_err = exp_id ? r1_err : r0_err;
                n_cmp++;
                if ({r1_done, r0_done} !== id_to_onehot(exp_id)) begin
                    n_err++; $display("FAIL %s winner: done=%b expected %b", tag, {r1_done, r0_done}, id_to_onehot(exp_id));
                end
                n_cmp++;
                if (obs_err !== e_err) begin
                    n_err++; $display("FAIL %s err: got %b expected %b", tag, obs_err, e_err);
                end
                n_cmp++;
                if (gap != e_gap) begin
                    n_err++; $display("FAIL %s latency: got %0d cycles expected %0d", tag, gap, e_gap);
                end
                n_cmp++;
                if (count !== CNT_W'(model_q.size()) || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
                    n_err++; $display("FAIL %s occupancy: count=%0d full=%b empty=%b expected count %0d", tag, count, full, empty, model_q.size());
                end
                n_cmp++;
                if ({r0_x_out, r0_y_out, r1_x_out, r1_y_out} !== {exp_xo[0], exp_yo[0], exp_xo[1], exp_yo[1]}) begin
                    n_err++; $display("FAIL %s pop data: got %h expected %h", tag,
                        {r0_x_out, r0_y_out, r1_x_out, r1_y_out}, {exp_xo[0], exp_yo[0], exp_xo[1], exp_yo[1]});
                end
                n_cmp++;
                if ((push_cnt - ps) != e_push || (pop_cnt - pp) != e_pop) begin
                    n_err++; $display("FAIL %s strobes: push %0d pop %0d expected push %0d pop %0d", tag, push_cnt - ps, pop_cnt - pp, e_push, e_pop);
                end
                model_prio = ~exp_id;
                if (exp_id == 1'b0 && txq0.size() > 0) begin cur[0] = txq0.pop_front(); drive_req(0, 1'b1, cur[0]); end
                else if (exp_id == 1'b1 && txq1.size() > 0) begin cur[1] = txq1.pop_front(); drive_req(1, 1'b1, cur[1]); end
                else begin drive_req(int'(exp_id), 1'b0, cur[exp_id]); act[exp_id] = 1'b0; end
                ps = push_cnt; pp = pop_cnt;
                gap = 0; first = 1'b0;
            end else if (gap > 6) begin
                n_cmp++; n_err++;
                $display("FAIL %s timeout: no done after %0d cycles, expected at most 4", tag, gap);
                r0_req = 1'b0; r1_req = 1'b0;
                act[0] = 1'b0; act[1] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 1'b0; r0_op = 1'b0; r0_x_in = 4'h0; r0_y_in = 4'h0;
        r1_req = 1'b0; r1_op = 1'b0; r1_x_in = 4'h0; r1_y_in = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({r0_done, r0_err, r0_x_out, r0_y_out, r1_done, r1_err, r1_x_out, r1_y_out,
             stk_push, stk_pop, stk_x_in, stk_y_in, busy, full} !== 32'h0 || count !== 7'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL reset_state: outputs not cleared, count=%0d empty=%b busy=%b", count, empty, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        txn_t t;
        t = '{op: OP_PUSH, x: 4'h3, y: 4'h5}; txq0.push_back(t);
        t = '{op: OP_PUSH, x: 4'h7, y: 4'h2}; txq0.push_back(t);
        t = '{op: OP_POP,  x: 4'h0, y: 4'h0}; txq0.push_back(t);
        txq0.push_back(t);
        run_engine("push_pop");
    endtask

    task automatic test_pop_empty();
        txn_t t;
        t = '{op: OP_POP, x: 4'h0, y: 4'h0};
        txq1.push_back(t);
        run_engine("pop_empty");
    endtask

    task automatic test_fill();
        txn_t t;
        for (int i = 0; i < DEPTH; i++) txq0.push_back(rand_txn(1));
        t = '{op: OP_PUSH, x: 4'hF, y: 4'hF};
        txq0.push_back(t);
        run_engine("fill");
        for (int i = 0; i < DEPTH + 1; i++) txq1.push_back(rand_txn(2));
        run_engine("drain");
    endtask

    task automatic test_contention(input int n);
        for (int i = 0; i < n; i++) begin
            txq0.push_back(rand_txn(0));
            txq1.push_back(rand_txn(0));
        end
        run_engine("contention");
    endtask

    task automatic test_req_drop();
        logic [3:0] a, b;
        int c0;
        a = 4'($urandom_range(15, 0)); b = 4'($urandom_range(15, 0));
        c0 = model_q.size();
        @(negedge clk);
        r0_req = 1'b1; r0_op = OP_PUSH; r0_x_in = a; r0_y_in = b;
        @(negedge clk);
        n_cmp++;
        if (stk_push !== 1'b1 || stk_pop !== 1'b0 || {stk_x_in, stk_y_in} !== {a, b}) begin
            n_err++; $display("FAIL req_drop issue: push=%b pop=%b data=%h expected push 1 data %h", stk_push, stk_pop, {stk_x_in, stk_y_in}, {a, b});
        end
        r0_req = 1'b0; r0_op = OP_POP; r0_x_in = ~a; r0_y_in = ~b;
        @(negedge clk);
        n_cmp++;
        if (r0_done !== 1'b1 || r0_err !== 1'b0 || r1_done !== 1'b0 || count !== CNT_W'(c0 + 1)) begin
            n_err++; $display("FAIL req_drop done: done=%b err=%b count=%0d expected done 1 err 0 count %0d", r0_done, r0_err, count, c0 + 1);
        end
        model_q.push_back({a, b});
        model_prio = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (r0_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL req_drop idle: done=%b busy=%b expected 0 0", r0_done, busy);
        end
        txq0.push_back(rand_txn(2));
        run_engine("req_drop_pop");
    endtask

    task automatic test_reset_mid_capture();
        txq0.push_back(rand_txn(1));
        run_engine("pre_reset_push");
        @(negedge clk);
        r0_req = 1'b1; r0_op = OP_POP;
        @(negedge clk);
        n_cmp++;
        if (stk_pop !== 1'b1) begin
            n_err++; $display("FAIL reset_capture issue: stk_pop=%b expected 1", stk_pop);
        end
        @(negedge clk);
        rst = 1'b1; r0_req = 1'b0;
        #1;
        n_cmp++;
        if ({r0_done, r0_err, r0_x_out, r0_y_out, r1_done, r1_err, r1_x_out, r1_y_out,
             stk_push, stk_pop, stk_x_in, stk_y_in, busy, full} !== 32'h0 || count !== 7'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL reset_capture clear: outputs not cleared, count=%0d busy=%b", count, busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (r0_done !== 1'b0 || r1_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_capture after: done=%b%b busy=%b expected 00 0", r1_done, r0_done, busy);
        end
        txq0.push_back(rand_txn(1));
        txq1.push_back(rand_txn(1));
        run_engine("post_reset_prio");
    endtask

    task automatic test_random();
        int n0, n1;
        for (int r = 0; r < 6; r++) begin
            n0 = $urandom_range(8, 0);
            n1 = $urandom_range(8, 1);
            for (int i = 0; i < n0; i++) txq0.push_back(rand_txn(0));
            for (int i = 0; i < n1; i++) txq1.push_back(rand_txn(0));
            run_engine("random");
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_fill();
        test_contention(8);
        test_req_drop();
        test_reset_mid_capture();
        test_contention(10);
        test_random();
        n_cmp++;
        if (both_cnt != 0) begin
            n_err++; $display("FAIL strobe_overlap: push and pop together %0d times, expected 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
